// File: rtl/fifo_cell_alloc_pkg.sv
// Shared constants, FSM encoding and pointer helper for the FIFO cell allocator.
package fifo_cell_alloc_pkg;

  localparam int SIZE_ONE   = 1;
  localparam int FREE_PORTS = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

  // Circular pointer increment for depths that need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_cell_alloc_free_bank.sv
// One bank of the free list: circular FIFO of cell IDs with an asynchronously
// readable head so a grant can be issued in the same cycle as the request.
module fifo_cell_alloc_free_bank
  import fifo_cell_alloc_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int ID_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ID_W-1:0]         push_id,
  input  logic                    pop,
  output logic [ID_W-1:0]         head_id,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = PTR_W'(wrap_inc(32'(wr_ptr_reg), DEPTH));
    if (pop)  rd_ptr_next = PTR_W'(wrap_inc(32'(rd_ptr_reg), DEPTH));
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; the init sweep rewrites every slot before use.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg] <= push_id;
  end

  assign head_id = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/fifo_cell_alloc.sv
// Cell allocator with deterministic FIFO reuse: two balanced free-list banks,
// same-cycle grant, dual free ports and a per-cell bitmap rejecting bad frees.
module fifo_cell_alloc
  import fifo_cell_alloc_pkg::*;
#(
  parameter int CELL_NUM      = 1024,
  parameter int LEN_WIDTH     = 1,
  parameter int FREE_PORT_NUM = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_mem_req,
  input  logic [LEN_WIDTH-1:0]          alloc_mem_size,
  output logic [$clog2(CELL_NUM)-1:0]   alloc_cell_id,
  output logic                          alloc_mem_success,
  input  logic [1:0]                    free_mem_req,
  input  logic [2*LEN_WIDTH-1:0]        free_mem_size,
  input  logic [2*$clog2(CELL_NUM)-1:0] free_cell_id,
  output logic                          init_done,
  output logic [$clog2(CELL_NUM):0]     free_count,
  output logic                          err_free
);

  localparam int ID_W   = $clog2(CELL_NUM);
  localparam int HALF   = CELL_NUM / 2;
  localparam int HALF_W = $clog2(HALF);
  localparam int BCNT_W = $clog2(HALF) + 1;
  localparam int CNT_W  = ID_W + 1;
  localparam logic [HALF_W-1:0] INIT_LAST = HALF_W'(HALF - 1);

  generate
    if (FREE_PORT_NUM != FREE_PORTS) begin : g_bad_free_ports
      $error("fifo_cell_alloc: FREE_PORT_NUM must be 2");
    end
    if ((CELL_NUM < 4) || (CELL_NUM % 2 != 0)) begin : g_bad_cell_num
      $error("fifo_cell_alloc: CELL_NUM must be even and >= 4");
    end
  endgenerate

  init_state_e       state_reg, state_next;
  logic [HALF_W-1:0] init_idx_reg, init_idx_next;
  logic [CELL_NUM-1:0] bitmap_reg;
  logic              err_free_reg;

  logic [1:0]        bank_push, bank_pop;
  logic [ID_W-1:0]   bank_push_id [2];
  logic [ID_W-1:0]   bank_head    [2];
  logic [BCNT_W-1:0] bank_count   [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      fifo_cell_alloc_free_bank #(
        .DEPTH (HALF),
        .ID_W  (ID_W)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .push    (bank_push[gi]),
        .push_id (bank_push_id[gi]),
        .pop     (bank_pop[gi]),
        .head_id (bank_head[gi]),
        .count   (bank_count[gi])
      );
    end
  endgenerate

  logic [CNT_W-1:0] total;
  logic             pop_from_1;
  logic             alloc_ok;
  logic [ID_W-1:0]  id1, id2;
  logic             size1_ok, size2_ok;
  logic             free_ok1, free_ok2;

  assign total      = CNT_W'(bank_count[0]) + CNT_W'(bank_count[1]);
  // Always drain the fuller bank so the two counts never drift apart by more than one.
  assign pop_from_1 = (bank_count[0] < bank_count[1]);
  assign init_done  = (state_reg == ST_RUN);
  assign alloc_ok   = alloc_mem_req && init_done && (total != '0) &&
                      (alloc_mem_size == LEN_WIDTH'(SIZE_ONE));

  assign id1      = free_cell_id[2*ID_W-1:ID_W];
  assign id2      = free_cell_id[ID_W-1:0];
  assign size1_ok = (free_mem_size[2*LEN_WIDTH-1:LEN_WIDTH] == LEN_WIDTH'(SIZE_ONE));
  assign size2_ok = (free_mem_size[LEN_WIDTH-1:0] == LEN_WIDTH'(SIZE_ONE));
  assign free_ok1 = free_mem_req[1] && init_done && size1_ok && bitmap_reg[id1];
  assign free_ok2 = free_mem_req[0] && init_done && size2_ok && bitmap_reg[id2] &&
                    !(free_ok1 && (id1 == id2));

  assign alloc_mem_success = alloc_ok;
  assign alloc_cell_id     = alloc_ok ? (pop_from_1 ? bank_head[1] : bank_head[0]) : '0;
  assign free_count        = total;
  assign err_free          = err_free_reg;

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    case (state_reg)
      ST_INIT: begin
        if (init_idx_reg == INIT_LAST) state_next = ST_RUN;
        else                           init_idx_next = init_idx_reg + HALF_W'(1);
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
    end
  end

  logic [ID_W-1:0] one_id;
  logic            one_to_1;

  always_comb begin
    bank_push       = '0;
    bank_pop        = '0;
    bank_push_id[0] = '0;
    bank_push_id[1] = '0;
    one_id          = free_ok1 ? id1 : id2;
    one_to_1        = alloc_ok ? pop_from_1 : (bank_count[0] > bank_count[1]);
    if (state_reg == ST_INIT) begin
      bank_push       = 2'b11;
      bank_push_id[0] = ID_W'({init_idx_reg, 1'b0});
      bank_push_id[1] = ID_W'({init_idx_reg, 1'b1});
    end else begin
      bank_pop[0] = alloc_ok && !pop_from_1;
      bank_pop[1] = alloc_ok && pop_from_1;
      if (free_ok1 && free_ok2) begin
        bank_push       = 2'b11;
        bank_push_id[0] = id1;
        bank_push_id[1] = id2;
      end else if (free_ok1 || free_ok2) begin
        // Refilling the bank being popped keeps the counts as they were.
        bank_push[one_to_1]    = 1'b1;
        bank_push_id[one_to_1] = one_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_reg   <= '0;
      err_free_reg <= 1'b0;
    end else begin
      if (alloc_ok) bitmap_reg[alloc_cell_id] <= 1'b1;
      if (free_ok1) bitmap_reg[id1] <= 1'b0;
      if (free_ok2) bitmap_reg[id2] <= 1'b0;
      if ((free_mem_req[1] && !free_ok1) || (free_mem_req[0] && !free_ok2))
        err_free_reg <= 1'b1;
    end
  end

endmodule
